max_pooler: RTL and testbench
=============================

# max_pooler

2x2, stride-2 max-pooling stage directly downstream of the convolver. Once the convolver signals end-of-convolution, it reads the completed FEATURE_WIDTH x FEATURE_WIDTH signed feature map from the feature RAM, one word per request/valid handshake. It reduces each non-overlapping 2x2 window to its signed maximum, with optional ReLU. It writes the (FEATURE_WIDTH/2)² results, row-major, into the pool RAM.

## Interface
- ADDR_WIDTH, 14, width of both RAM address buses; FEATURE_WIDTH² must be ≤ 2^ADDR_WIDTH.
- FEATURE_WIDTH, 32, feature map side; must be even; OUT_WIDTH = FEATURE_WIDTH/2.
- BITWIDTH, 8, data words are 2*BITWIDTH bits, signed.
- RELU_EN, 0, 1 clamps negative window maxima to 0 before write.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  level; driven by convolver eoc; sampled in IDLE.
- fea_ram_en  out  1  read request to feature RAM.
- fea_ram_addr  out  ADDR_WIDTH  feature RAM read address.
- fea_ram_din  in  2*BITWIDTH  signed read data; valid when fea_ram_data_val=1.
- fea_ram_data_val  in  1  read data valid; one pulse per request.
- pool_ram_en  out  1  pool RAM enable.
- pool_ram_wen  out  1  pool RAM write enable.
- pool_ram_addr  out  ADDR_WIDTH  pool RAM write address.
- pool_ram_dout  out  2*BITWIDTH  signed write data.
- done  out  1  whole map pooled.

## Operation
- Counters:
  - pr, pc: output row/col, 0..OUT_WIDTH-1.
  - k: window element, 0..3, k = 2*dy + dx.
  - Running max register mx, signed 2*BITWIDTH.
- Read address = (2*pr+dy)*FEATURE_WIDTH + 2*pc + dx, truncated to ADDR_WIDTH.
- Write address = pr*OUT_WIDTH + pc.
- All outputs are registered.
- FSM, 5 states:
  - IDLE: all outputs 0. Go to REQ with pr=pc=k=0 when start=1.
  - REQ: fea_ram_en=1, address held stable. On fea_ram_data_val=1:
    - mx ← fea_ram_din if k=0, else the signed max of mx and fea_ram_din.
    - If k<3: k++ and go to STEP. If k=3: go to WRITE.
  - STEP: fea_ram_en=0 for exactly one cycle; fea_ram_data_val ignored; the new address is presented. Go to REQ.
  - WRITE: one cycle with pool_ram_en=pool_ram_wen=1, pool_ram_dout = (RELU_EN && mx<0) ? 0 : mx.
    - k←0; pc++; on pc wrap to 0, pr++.
    - After writing pr=pc=OUT_WIDTH-1, go to DONE; otherwise go to REQ.
  - DONE: done=1 held. Go to IDLE when start=0, clearing done.
- fea_ram_data_val is ignored in IDLE, STEP, WRITE and DONE.
- start changes outside IDLE/DONE are ignored.
- Equal values: compare is strict greater-than; the result is the same either way.
- Arithmetic: signed comparison only. No widening or saturation; the output equals one input word, or 0 under ReLU.

## Timing
- Reset values: every output 0, state IDLE, all counters and mx 0.
- Reset mid-operation immediately aborts: en/wen drop asynchronously. No partial write completes after resetn falls.
- start=1 in IDLE → fea_ram_en=1 with fea_ram_addr=0 on the next cycle.
- With a RAM returning data_val L≥1 cycles after en rises, each element costs L+1 cycles: REQ for L cycles plus STEP, except k=3, which goes straight to WRITE.
- Each window costs 4L+4 cycles. With L=1: 8 cycles per window, 2048 cycles per 32x32 map, plus 1 cycle IDLE→REQ.
- data_val in the same cycle en first rises (L=0) is accepted; the RAM model must not do this for a stale address.
- pool_ram_dout and pool_ram_addr hold their last written values after WRITE; en/wen are high only in WRITE.
- done rises the cycle after the last WRITE.

## Test plan
- Ramp: fea[i]=i for i=0..1023, L=1, start=1 → 256 writes, pool[0]=33, pool[1]=35, pool[16]=97, pool[255]=1023. done rises 2049 cycles after start.
- Signed/ReLU: window {-32768, -5, -1, -200}, rest 0 → pool[0] = -1 (0xFFFF) with RELU_EN=0, and 0x0000 with RELU_EN=1.
- Position sweep: 0x7FFF placed at each of the 4 positions of window (pr=3, pc=7), background -1 → pool[55]=0x7FFF each time; all other outputs are -1.
- Variable latency: random L in 1..6 per request, plus spurious data_val pulses injected in STEP, IDLE and WRITE → pool contents identical to the ramp case; exactly 1024 accepted reads.
- Reset mid-run: assert resetn=0 during the 100th WRITE → all outputs 0 within the reset cycle; after release with start=1, the run restarts at addr 0 and completes 256 writes.
- Restart: start held high after done → no new requests; start 0 for 1 cycle then 1 → done clears, and a second full run produces identical results.

Source files
------------

// File: rtl/max_pooler.sv
// 2x2 stride-2 max-pooling stage. Walks each non-overlapping 2x2 window of
// the FEATURE_WIDTH x FEATURE_WIDTH feature map, fetching one word per
// request/valid handshake. Writes the signed window maximum (optionally
// ReLU-clamped) row-major into the pool RAM.
module max_pooler #(
  parameter int ADDR_WIDTH    = 14,
  parameter int FEATURE_WIDTH = 32,
  parameter int BITWIDTH      = 8,
  parameter int RELU_EN       = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    fea_ram_en,
  output logic [ADDR_WIDTH-1:0]   fea_ram_addr,
  input  logic [2*BITWIDTH-1:0]   fea_ram_din,
  input  logic                    fea_ram_data_val,
  output logic                    pool_ram_en,
  output logic                    pool_ram_wen,
  output logic [ADDR_WIDTH-1:0]   pool_ram_addr,
  output logic [2*BITWIDTH-1:0]   pool_ram_dout,
  output logic                    done
);

  localparam int OUT_WIDTH = FEATURE_WIDTH / 2;
  localparam int CW        = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int DW        = 2 * BITWIDTH;
  localparam logic [CW-1:0] LAST = CW'(OUT_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STEP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         pr, pr_n, pc, pc_n;
  logic [1:0]            k, k_n;
  logic signed [DW-1:0]  mx, mx_n;
  logic                  fea_en_n, pool_en_n, done_n;
  logic [ADDR_WIDTH-1:0] pool_addr_n;
  logic [DW-1:0]         pool_dout_n;

  // Feature address: {r,dy} is 2*r+dy and {c,dx} is 2*c+dx.
  function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [CW-1:0] r,
                                                    input logic [CW-1:0] c,
                                                    input logic [1:0]    kk);
    logic [31:0] a;
    a = 32'({r, kk[1]}) * 32'(FEATURE_WIDTH) + 32'({c, kk[0]});
    return a[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [CW-1:0] r,
                                                    input logic [CW-1:0] c);
    logic [31:0] a;
    a = 32'(r) * 32'(OUT_WIDTH) + 32'(c);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // Next-state, counter and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_n     = state;
    pr_n        = pr;
    pc_n        = pc;
    k_n         = k;
    mx_n        = mx;
    fea_en_n    = 1'b0;
    pool_en_n   = 1'b0;
    done_n      = 1'b0;
    pool_addr_n = pool_ram_addr;
    pool_dout_n = pool_ram_dout;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_REQ;
          pr_n     = '0;
          pc_n     = '0;
          k_n      = '0;
          fea_en_n = 1'b1;
        end
      end
      S_REQ: begin
        fea_en_n = 1'b1;
        if (fea_ram_data_val) begin
          fea_en_n = 1'b0;
          if (k == 2'd0 || $signed(fea_ram_din) > mx) mx_n = $signed(fea_ram_din);
          if (k == 2'd3) begin
            state_n     = S_WRITE;
            pool_en_n   = 1'b1;
            pool_addr_n = wr_addr(pr, pc);
            pool_dout_n = (RELU_EN != 0 && mx_n[DW-1]) ? '0 : mx_n;
          end else begin
            state_n = S_STEP;
            k_n     = k + 2'd1;
          end
        end
      end
      S_STEP: begin
        state_n  = S_REQ;
        fea_en_n = 1'b1;
      end
      S_WRITE: begin
        k_n = '0;
        if (pc == LAST) begin
          pc_n = '0;
          if (pr == LAST) begin
            pr_n    = '0;
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            pr_n     = pr + CW'(1);
            state_n  = S_REQ;
            fea_en_n = 1'b1;
          end
        end else begin
          pc_n     = pc + CW'(1);
          state_n  = S_REQ;
          fea_en_n = 1'b1;
        end
      end
      S_DONE: begin
        done_n = 1'b1;
        if (!start) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset aborts any access at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      pr            <= '0;
      pc            <= '0;
      k             <= '0;
      mx            <= '0;
      fea_ram_en    <= 1'b0;
      fea_ram_addr  <= '0;
      pool_ram_en   <= 1'b0;
      pool_ram_wen  <= 1'b0;
      pool_ram_addr <= '0;
      pool_ram_dout <= '0;
      done          <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state         <= state_n;
      pr            <= pr_n;
      pc            <= pc_n;
      k             <= k_n;
      mx            <= mx_n;
      fea_ram_en    <= fea_en_n;
      fea_ram_addr  <= rd_addr(pr_n, pc_n, k_n);
      pool_ram_en   <= pool_en_n;
      pool_ram_wen  <= pool_en_n;
      pool_ram_addr <= pool_addr_n;
      pool_ram_dout <= pool_dout_n;
      done          <= done_n;
    end
  end

endmodule

// File: tb/tb_max_pooler.sv
// Directed bench for max_pooler: a feature RAM model with programmable read
// latency and spurious valid pulses, a pool RAM capture for a plain and a
// ReLU instance, and a hand-derived ramp model.
module tb_max_pooler;

  localparam int AW = 14;
  localparam int FW = 32;
  localparam int BW = 8;
  localparam int DW = 2 * BW;
  localparam int OW = FW / 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          fea_ram_data_val = 1'b0;
  logic [DW-1:0] fea_ram_din = '0;

  logic          fea_ram_en, pool_ram_en, pool_ram_wen, done;
  logic [AW-1:0] fea_ram_addr, pool_ram_addr;
  logic [DW-1:0] pool_ram_dout;

  logic          r_fea_ram_en, r_pool_ram_en, r_pool_ram_wen, r_done;
  logic [AW-1:0] r_fea_ram_addr, r_pool_ram_addr;
  logic [DW-1:0] r_pool_ram_dout;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] fea_mem   [FW*FW];
  logic [DW-1:0] pool_mem  [OW*OW];
  logic [DW-1:0] pool_relu [OW*OW];

  int writes = 0;
  int accepted = 0;
  int req_cyc = 0;
  int cur_l = 1;
  int lat_max = 1;
  bit spur = 1'b0;

  max_pooler #(.ADDR_WIDTH(AW), .FEATURE_WIDTH(FW), .BITWIDTH(BW), .RELU_EN(0)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .fea_ram_en(fea_ram_en), .fea_ram_addr(fea_ram_addr),
    .fea_ram_din(fea_ram_din), .fea_ram_data_val(fea_ram_data_val),
    .pool_ram_en(pool_ram_en), .pool_ram_wen(pool_ram_wen),
    .pool_ram_addr(pool_ram_addr), .pool_ram_dout(pool_ram_dout),
    .done(done)
  );

  max_pooler #(.ADDR_WIDTH(AW), .FEATURE_WIDTH(FW), .BITWIDTH(BW), .RELU_EN(1)) dut_relu (
    .clk(clk), .resetn(resetn), .start(start),
    .fea_ram_en(r_fea_ram_en), .fea_ram_addr(r_fea_ram_addr),
    .fea_ram_din(fea_ram_din), .fea_ram_data_val(fea_ram_data_val),
    .pool_ram_en(r_pool_ram_en), .pool_ram_wen(r_pool_ram_wen),
    .pool_ram_addr(r_pool_ram_addr), .pool_ram_dout(r_pool_ram_dout),
    .done(r_done)
  );

  always #5 clk = ~clk;

  // RAM models: valid arrives in the L-th cycle of a request, optional
  // spurious valids while no request is open, pool writes captured.
  always @(negedge clk) begin
    if (fea_ram_en) begin
      req_cyc++;
      if (req_cyc >= cur_l) begin
        fea_ram_data_val = 1'b1;
        fea_ram_din      = fea_mem[fea_ram_addr[9:0]];
        accepted++;
        req_cyc = 0;
        cur_l   = (lat_max > 1) ? $urandom_range(lat_max, 1) : 1;
      end else begin
        fea_ram_data_val = 1'b0;
      end
    end else begin
      req_cyc = 0;
      if (spur) begin
        fea_ram_data_val = 1'($urandom_range(1, 0));
        fea_ram_din      = DW'($urandom);
      end else begin
        fea_ram_data_val = 1'b0;
      end
    end
    if (pool_ram_en && pool_ram_wen) begin
      pool_mem[pool_ram_addr[7:0]] = pool_ram_dout;
      writes++;
    end
    if (r_pool_ram_en && r_pool_ram_wen) pool_relu[r_pool_ram_addr[7:0]] = r_pool_ram_dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ramp_max(input int p);
    int r, c;
    r = p / OW;
    c = p % OW;
    return (2 * r + 1) * FW + 2 * c + 1;
  endfunction

  task automatic ramp_fill();
    for (int i = 0; i < FW * FW; i++) fea_mem[i] = DW'(i);
  endtask

  task automatic check_ramp(input string tag);
    int bad;
    bad = 0;
    for (int p = 0; p < OW * OW; p++)
      if (pool_mem[p] !== DW'(ramp_max(p)) || pool_relu[p] !== DW'(ramp_max(p))) bad++;
    check({tag, "_bad_words"}, bad, 0);
    check({tag, "_pool0"},   pool_mem[0],   33);
    check({tag, "_pool1"},   pool_mem[1],   35);
    check({tag, "_pool16"},  pool_mem[16],  97);
    check({tag, "_pool255"}, pool_mem[255], 1023);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fea_en"},    fea_ram_en,    0);
    check({tag, "_fea_addr"},  fea_ram_addr,  0);
    check({tag, "_pool_en"},   pool_ram_en,   0);
    check({tag, "_pool_wen"},  pool_ram_wen,  0);
    check({tag, "_pool_addr"}, pool_ram_addr, 0);
    check({tag, "_pool_dout"}, pool_ram_dout, 0);
    check({tag, "_done"},      done,          0);
  endtask

  // Starts a run and waits (bounded) for done; reports cycles to done.
  task automatic run(input string tag, output int cycles);
    int wbase;
    wbase = writes;
    @(negedge clk);
    start  = 1'b1;
    cycles = 0;
    while (cycles < 30000) begin
      @(negedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        check({tag, "_first_en"},   fea_ram_en,   1);
        check({tag, "_first_addr"}, fea_ram_addr, 0);
      end
      if (done) break;
    end
    check({tag, "_done"},   done, 1);
    check({tag, "_writes"}, writes - wbase, OW * OW);
  endtask

  task automatic end_run(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_done_clear"}, done, 0);
  endtask

  initial begin
    int cyc, abase, bad, pos, addr, guard;

    for (int i = 0; i < FW * FW; i++) fea_mem[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    resetn = 1'b1;

    // Ramp with L=1, including the done latency.
    ramp_fill();
    abase = accepted;
    run("ramp", cyc);
    check("ramp_done_cycles", cyc, 2049);
    check("ramp_accepted", accepted - abase, FW * FW);
    check_ramp("ramp");

    // start held high after done: no new requests, done stays.
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (fea_ram_en || !done) bad++;
    end
    check("hold_after_done", bad, 0);
    end_run("ramp");

    // Second run gives identical results.
    for (int p = 0; p < OW * OW; p++) pool_mem[p] = '0;
    run("restart", cyc);
    check_ramp("restart");
    end_run("restart");

    // Signed window, plain and ReLU.
    for (int i = 0; i < FW * FW; i++) fea_mem[i] = '0;
    fea_mem[0]  = 16'h8000;
    fea_mem[1]  = 16'hFFFB;
    fea_mem[32] = 16'hFFFF;
    fea_mem[33] = 16'hFF38;
    run("signed", cyc);
    check("signed_pool0",      pool_mem[0],  16'hFFFF);
    check("signed_relu_pool0", pool_relu[0], 16'h0000);
    check("signed_pool1",      pool_mem[1],  16'h0000);
    end_run("signed");

    // Maximum at each position of window (3,7) over a -1 background.
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < FW * FW; i++) fea_mem[i] = 16'hFFFF;
      addr = (6 + kk / 2) * FW + 14 + kk % 2;
      fea_mem[addr] = 16'h7FFF;
      run($sformatf("sweep%0d", kk), cyc);
      check($sformatf("sweep%0d_pool55", kk), pool_mem[55], 16'h7FFF);
      check($sformatf("sweep%0d_relu55", kk), pool_relu[55], 16'h7FFF);
      bad = 0;
      for (int p = 0; p < OW * OW; p++)
        if (p != 55 && (pool_mem[p] !== 16'hFFFF || pool_relu[p] !== 16'h0000)) bad++;
      check($sformatf("sweep%0d_background", kk), bad, 0);
      end_run($sformatf("sweep%0d", kk));
    end

    // Random latency 1..6 with spurious valids outside requests.
    ramp_fill();
    lat_max = 6;
    spur    = 1'b1;
    abase   = accepted;
    run("varlat", cyc);
    check("varlat_accepted", accepted - abase, FW * FW);
    check_ramp("varlat");
    end_run("varlat");
    lat_max = 1;
    spur    = 1'b0;

    // Reset during the 100th write, then a clean restart.
    abase = writes;
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    pos   = 0;
    while (guard < 5000) begin
      @(negedge clk);
      #1;
      guard++;
      if (writes - abase == 100) break;
    end
    check("midrst_reached_write", writes - abase, 100);
    check("midrst_in_write", pool_ram_en, 1);
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    #1;
    check("midrst_no_extra_write", writes - abase, 100);
    resetn = 1'b1;
    for (int p = 0; p < OW * OW; p++) pool_mem[p] = '0;
    run("after_rst", cyc);
    check_ramp("after_rst");
    end_run("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
